// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop; one bit per CLK.
// Optional macro UART_TX_STOP2_EN adds the STOP2 input for a two-cycle stop phase.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_STOP2_EN
  input  logic                  STOP2,
`endif
  output logic [SEL_WIDTH-1:0]  MUX_SEL,
  output logic                  SER_DATA,
  output logic                  PAR_BIT,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [SEL_WIDTH-1:0] SEL_START  = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] SEL_DATA   = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_PARITY = SEL_WIDTH'(2);
  localparam logic [SEL_WIDTH-1:0] SEL_STOP   = SEL_WIDTH'(3);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_reg;
  logic                  par_en_q;
  logic                  accept;
`ifdef UART_TX_STOP2_EN
  logic                  stop2_q;
  logic                  stop_second;
`endif

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // A stop phase still owing its second cycle cannot accept a new frame.
  always_comb begin
    accept = 1'b0;
    if (DATA_VALID) begin
      if (state == ST_IDLE) begin
        accept = 1'b1;
      end else if (state == ST_STOP) begin
`ifdef UART_TX_STOP2_EN
        accept = !(stop2_q && !stop_second);
`else
        accept = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_reg   <= 1'b0;
      par_en_q  <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg <= P_DATA;
      par_reg   <= parity_of(P_DATA, PAR_TYP);
      par_en_q  <= PAR_EN;
      state     <= ST_START;
`ifdef UART_TX_STOP2_EN
      stop2_q     <= STOP2;
      stop_second <= 1'b0;
`endif
    end else begin
      case (state)
        ST_START: begin
          bit_cnt <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          shift_reg <= shift_reg >> 1;
          // Counter holds at the last bit so it never wraps.
          if (bit_cnt == LAST_BIT) begin
            state <= par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: state <= ST_STOP;
        ST_STOP: begin
`ifdef UART_TX_STOP2_EN
          if (stop2_q && !stop_second) begin
            stop_second <= 1'b1;
          end else begin
            stop_second <= 1'b0;
            state       <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    MUX_SEL = SEL_STOP;
    case (state)
      ST_START:  MUX_SEL = SEL_START;
      ST_DATA:   MUX_SEL = SEL_DATA;
      ST_PARITY: MUX_SEL = SEL_PARITY;
      default:   MUX_SEL = SEL_STOP;
    endcase
  end

  assign SER_DATA = shift_reg[0];
  assign PAR_BIT  = par_reg;
  assign BUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: each accepted frame queues its expected per-cycle outputs.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
`ifdef UART_TX_STOP2_EN
  logic       STOP2;
`endif
  logic [1:0] MUX_SEL;
  logic       SER_DATA;
  logic       PAR_BIT;
  logic       BUSY;

  uart_tx_ctrl #(.DATA_WIDTH(8), .SEL_WIDTH(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
`ifdef UART_TX_STOP2_EN
    .STOP2      (STOP2),
`endif
    .MUX_SEL    (MUX_SEL),
    .SER_DATA   (SER_DATA),
    .PAR_BIT    (PAR_BIT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] sel;
    logic       ser;
    logic       ser_chk;
    logic       par;
    logic       par_chk;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    logic p;
    p = (^d) ^ pt;
    exp_q.push_back('{2'b00, 1'b0, 1'b0, p, 1'b1, 1'b1});
    for (int i = 0; i < 8; i++) exp_q.push_back('{2'b01, d[i], 1'b1, p, 1'b1, 1'b1});
    if (pe) exp_q.push_back('{2'b10, 1'b0, 1'b0, p, 1'b1, 1'b1});
    exp_q.push_back('{2'b11, 1'b0, 1'b0, p, 1'b1, 1'b1});
    if (s2) exp_q.push_back('{2'b11, 1'b0, 1'b0, p, 1'b1, 1'b1});
  endtask

  // Drive one cycle of inputs; an empty queue means the DUT is idle or in its final stop cycle.
  task automatic step(input logic dv, input logic [7:0] d, input logic pe, input logic pt,
                      input logic s2);
    exp_t e;
    @(negedge CLK);
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
`ifdef UART_TX_STOP2_EN
    STOP2      = s2;
`endif
    if (dv && exp_q.size() == 0) push_frame(d, pe, pt, s2);
    @(posedge CLK);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_val("mux_sel", 8'(MUX_SEL), 8'(e.sel));
    check_val("busy", 8'(BUSY), 8'(e.busy));
    if (e.ser_chk) check_val("ser_data", 8'(SER_DATA), 8'(e.ser));
    if (e.par_chk) check_val("par_bit", 8'(PAR_BIT), 8'(e.par));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
`ifdef UART_TX_STOP2_EN
    STOP2      = 1'b0;
`endif
    #3;
    check_val("rst_mux_sel", 8'(MUX_SEL), 8'h03);
    check_val("rst_busy", 8'(BUSY), 8'h00);
    check_val("rst_ser", 8'(SER_DATA), 8'h00);
    check_val("rst_par", 8'(PAR_BIT), 8'h00);
    @(negedge CLK);
    RST = 1'b1;
    idle(2);

    // Even parity, odd parity, then no parity.
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(12);
    step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
    idle(12);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(11);

    // Request held through the frame: only the stop cycle accepts it.
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    idle(12);

    // Request pulsed while bit 3 is on the line.
    step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle(10);

    // Asynchronous reset while bit 4 is on the line, then a fresh frame.
    step(1'b1, 8'h96, 1'b1, 1'b0, 1'b0);
    idle(5);
    #2;
    RST = 1'b0;
    #1;
    check_val("midrst_mux_sel", 8'(MUX_SEL), 8'h03);
    check_val("midrst_busy", 8'(BUSY), 8'h00);
    check_val("midrst_ser", 8'(SER_DATA), 8'h00);
    check_val("midrst_par", 8'(PAR_BIT), 8'h00);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    idle(2);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(12);

`ifdef UART_TX_STOP2_EN
    // Two stop cycles; a held request is taken only in the second one.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    idle(13);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    check_val("drain", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
